t03_game_sequencer: RTL and testbench
=====================================

# t03_game_sequencer

Match-flow controller that drives the 3-bit `game_state` code and the two 12-bit health character fields consumed by the on-screen text decoder. It sequences title → READY → SET → FIGHT banner → fight → winner, times each banner phase, and keeps both players' health as two-digit decimal values. Health leaves the block already encoded as two 6-bit character codes, where digit n is code 26+n ('0'=26 … '9'=35). It sits between the input/collision logic and the text/HUD rendering path.

## Interface
- `PHASE_TICKS`, default 12_000_000: clock cycles each banner state (READY, SET, FIGHT banner) is held; must be ≥2.
- `HEALTH_INIT`, default 99: starting health, 0..99.

- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  start button, already synchronized to `clk`, level.
- `p1_dmg_valid`  in  1  one-cycle strobe: player 1 takes damage.
- `p1_dmg`  in  4  damage amount for player 1; values >9 treated as 9.
- `p2_dmg_valid`  in  1  one-cycle strobe: player 2 takes damage.
- `p2_dmg`  in  4  damage amount for player 2; values >9 treated as 9.
- `game_state`  out  3  0 TITLE, 1 READY, 2 SET, 3 BANNER, 4 FIGHT, 5 P1_WIN, 6 P2_WIN; 7 is never driven.
- `p1health`  out  12  {tens char, ones char} of player 1 health.
- `p2health`  out  12  {tens char, ones char} of player 2 health.
- `fight_active`  out  1  high exactly when `game_state`==4.

## Operation
- Reset is asynchronous, active-low. While `nrst`=0:
  - `game_state`=0.
  - Both health fields = HEALTH_INIT encoded (99 → {6'd35,6'd35}).
  - Phase counter = 0.
  - Start edge register = 0.
  - `fight_active`=0.
- Start press = a cycle where `start`=1 and the registered previous `start`=0. Holding `start` high produces exactly one press.
- TITLE:
  - On a start press, go to READY.
  - Reload both healths to HEALTH_INIT.
  - Load the counter with PHASE_TICKS-1.
- READY → SET → BANNER → FIGHT:
  - The counter decrements by 1 each cycle.
  - When it reads 0, advance to the next state and reload PHASE_TICKS-1. Leaving BANNER does not reload.
  - Start presses and damage strobes are ignored in these states.
- FIGHT damage, per player, with amount d:
  - Health value v = 10·tens + ones; new v = max(0, v−d).
  - Ones-digit borrow arithmetic: if ones ≥ d, ones −= d; else if tens > 0, tens −= 1 and ones += 10−d; else health = 00.
  - d=0 leaves health unchanged.
  - Both strobes in the same cycle: both are applied in that cycle.
- FIGHT end conditions, evaluated on post-damage values:
  - P2 health = 00 → P1_WIN.
  - Else P1 health = 00 → P2_WIN.
  - Both reach 00 in the same cycle → P1_WIN (tie priority to P1).
- P1_WIN / P2_WIN:
  - Hold; health is frozen and damage is ignored.
  - A start press returns to TITLE. Health stays frozen until the next TITLE → READY.
- Damage strobes outside FIGHT have no effect.
- Start presses outside TITLE and the win states are ignored.
- Reset asserted mid-match returns to TITLE with full health immediately (asynchronous), regardless of state or counter value.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start press sampled at edge k → `game_state`=1 after edge k.
- Each of READY, SET and BANNER is visible for exactly PHASE_TICKS cycles. FIGHT (4) appears PHASE_TICKS·3 cycles after READY first appears.
- Damage strobe sampled at edge k:
  - New health is visible after edge k (1-cycle latency).
  - If that hit ends the match, `game_state`=5/6 after the same edge k.
- Back-to-back strobes on consecutive cycles are each applied; none are dropped.
- `fight_active` changes on the same edge as `game_state`.

## Test plan
- Reset and start (PHASE_TICKS=4):
  - Assert `nrst`=0: expect state 0 and `p1health`=`p2health`=12'h8E3 ({35,35}).
  - Release reset, pulse `start`: expect state 1 for 4 cycles, then 2 for 4 cycles, then 3 for 4 cycles, then 4 with `fight_active`=1.
- Start held high 20 cycles in TITLE: exactly one transition to READY. No re-trigger when READY ends, and none in later states.
- BCD borrow, in FIGHT from 99:
  - P1 damage 9 → 90 ({35,26}).
  - Then damage 3 → 87 ({34,33}).
  - Then p1_dmg=15 → treated as 9 → 78.
- Win and saturation:
  - P2 at 05, damage 7 → `p2health`={26,26}, state 5 on the same edge.
  - Further strobes: health unchanged.
  - Start press → state 0.
- Simultaneous KO: both at 03, both strobed with damage 3 in one cycle → both 00, state 5 (P1 priority).
- Reset mid-SET with counter at 2 → immediate state 0 and full health. Damage strobes during READY/SET/BANNER leave health at 99.

Source files
------------

// File: rtl/t03_game_sequencer.sv
// Match-flow controller: title -> READY -> SET -> FIGHT banner -> fight -> winner,
// with two-digit BCD health per player presented as text-decoder character codes.
module t03_game_sequencer #(
    parameter int PHASE_TICKS = 12_000_000,
    parameter int HEALTH_INIT = 99
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        p1_dmg_valid,
    input  logic [3:0]  p1_dmg,
    input  logic        p2_dmg_valid,
    input  logic [3:0]  p2_dmg,
    output logic [2:0]  game_state,
    output logic [11:0] p1health,
    output logic [11:0] p2health,
    output logic        fight_active
);

    localparam int CNT_W = $clog2(PHASE_TICKS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PHASE_TICKS - 1);
    localparam logic [3:0] INIT_TENS = 4'(HEALTH_INIT / 10);
    localparam logic [3:0] INIT_ONES = 4'(HEALTH_INIT % 10);

    typedef enum logic [2:0] {
        S_TITLE  = 3'd0,
        S_READY  = 3'd1,
        S_SET    = 3'd2,
        S_BANNER = 3'd3,
        S_FIGHT  = 3'd4,
        S_P1_WIN = 3'd5,
        S_P2_WIN = 3'd6
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             fight_q;
    logic [3:0]       p1_tens_q, p1_ones_q, p2_tens_q, p2_ones_q;
    logic [7:0]       p1_d, p2_d;
    logic             press;

    // Saturating decimal subtract on a {tens, ones} BCD pair; damage above 9 clamps to 9.
    function automatic logic [7:0] bcd_sub(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [3:0] dmg);
        logic [3:0] d;
        d = (dmg > 4'd9) ? 4'd9 : dmg;
        if (ones >= d)
            return {tens, ones - d};
        else if (tens != 4'd0)
            return {tens - 4'd1, ones + 4'd10 - d};
        else
            return 8'h00;
    endfunction

    function automatic logic [11:0] encode(input logic [3:0] tens, input logic [3:0] ones);
        return {6'(tens) + 6'd26, 6'(ones) + 6'd26};
    endfunction

    assign press = start & ~start_q;
    assign p1_d  = p1_dmg_valid ? bcd_sub(p1_tens_q, p1_ones_q, p1_dmg) : {p1_tens_q, p1_ones_q};
    assign p2_d  = p2_dmg_valid ? bcd_sub(p2_tens_q, p2_ones_q, p2_dmg) : {p2_tens_q, p2_ones_q};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_TITLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            fight_q   <= 1'b0;
            p1_tens_q <= INIT_TENS;
            p1_ones_q <= INIT_ONES;
            p2_tens_q <= INIT_TENS;
            p2_ones_q <= INIT_ONES;
        end else begin
            start_q <= start;
            case (state_q)
                S_TITLE: begin
                    if (press) begin
                        state_q   <= S_READY;
                        cnt_q     <= CNT_RELOAD;
                        p1_tens_q <= INIT_TENS;
                        p1_ones_q <= INIT_ONES;
                        p2_tens_q <= INIT_TENS;
                        p2_ones_q <= INIT_ONES;
                    end
                end
                S_READY, S_SET: begin
                    if (cnt_q == '0) begin
                        state_q <= (state_q == S_READY) ? S_SET : S_BANNER;
                        cnt_q   <= CNT_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_BANNER: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FIGHT;
                        fight_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIGHT: begin
                    {p1_tens_q, p1_ones_q} <= p1_d;
                    {p2_tens_q, p2_ones_q} <= p2_d;
                    // P2 knocked out is checked first so a double KO goes to P1.
                    if (p2_d == 8'h00) begin
                        state_q <= S_P1_WIN;
                        fight_q <= 1'b0;
                    end else if (p1_d == 8'h00) begin
                        state_q <= S_P2_WIN;
                        fight_q <= 1'b0;
                    end
                end
                S_P1_WIN, S_P2_WIN: begin
                    if (press)
                        state_q <= S_TITLE;
                end
                default: begin
                    state_q <= S_TITLE;
                    fight_q <= 1'b0;
                end
            endcase
        end
    end

    assign game_state   = state_q;
    assign fight_active = fight_q;
    assign p1health     = encode(p1_tens_q, p1_ones_q);
    assign p2health     = encode(p2_tens_q, p2_ones_q);

endmodule

// File: tb/tb_t03_game_sequencer.sv
// Bench for t03_game_sequencer: directed match scenarios plus random play,
// compared every cycle against a plain-integer behavioural model.
module tb_t03_game_sequencer;

    localparam int P  = 4;
    localparam int HI = 99;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        p1v = 1'b0, p2v = 1'b0;
    logic [3:0]  p1d = 4'd0, p2d = 4'd0;
    logic [2:0]  game_state;
    logic [11:0] p1health, p2health;
    logic        fight_active;

    int total = 0;
    int bad   = 0;

    // Model state: match phase, health as integers 0..99, cycles spent in a banner phase.
    int m_state, m_p1, m_p2, m_elapsed;
    bit m_prev_start;

    t03_game_sequencer #(.PHASE_TICKS(P), .HEALTH_INIT(HI)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .p1_dmg_valid(p1v), .p1_dmg(p1d),
        .p2_dmg_valid(p2v), .p2_dmg(p2d),
        .game_state(game_state), .p1health(p1health), .p2health(p2health),
        .fight_active(fight_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] enc(input int v);
        logic [5:0] t, o;
        t = 6'(26 + v / 10);
        o = 6'(26 + v % 10);
        return {t, o};
    endfunction

    function automatic int hit(input int v, input int d);
        int dd;
        dd = (d > 9) ? 9 : d;
        return (v > dd) ? v - dd : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_p1 = HI; m_p2 = HI; m_elapsed = 0; m_prev_start = 0;
    endtask

    task automatic model_edge();
        bit pr;
        pr = start && !m_prev_start;
        m_prev_start = start;
        case (m_state)
            0: if (pr) begin m_state = 1; m_p1 = HI; m_p2 = HI; m_elapsed = 0; end
            1, 2, 3: begin
                if (m_elapsed == P - 1) begin m_state++; m_elapsed = 0; end
                else m_elapsed++;
            end
            4: begin
                if (p1v) m_p1 = hit(m_p1, p1d);
                if (p2v) m_p2 = hit(m_p2, p2d);
                if (m_p2 == 0) m_state = 5;
                else if (m_p1 == 0) m_state = 6;
            end
            default: if (pr) m_state = 0;
        endcase
    endtask

    task automatic check_all();
        check("state", 16'(game_state), 16'(m_state));
        check("fight_active", 16'(fight_active), 16'(m_state == 4));
        check("p1health", 16'(p1health), 16'(enc(m_p1)));
        check("p2health", 16'(p2health), 16'(enc(m_p2)));
    endtask

    task automatic cyc(input bit s, input bit a, input int da, input bit b, input int db);
        start = s; p1v = a; p1d = 4'(da); p2v = b; p2d = 4'(db);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 nrst = 1'b0;
        #1;
        model_reset();
        check_all();
        check("reset_p1_full", 16'(p1health), 16'h08E3);
        check("reset_p2_full", 16'(p2health), 16'h08E3);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        check("rst_state", 16'(game_state), 16'd0);
        check("rst_p1", 16'(p1health), 16'h08E3);
        check("rst_p2", 16'(p2health), 16'h08E3);
        nrst = 1'b1;

        // Start held for 20 cycles: one press only, through all banner phases.
        cyc(1, 0, 0, 0, 0);
        check("press_ready", 16'(game_state), 16'd1);
        for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0, 0);
        check("fight_reached", 16'(game_state), 16'd4);
        check("fight_active_hi", 16'(fight_active), 16'd1);

        // Decimal borrow on player 1.
        cyc(0, 1, 9, 0, 0);
        check("p1_90", 16'(p1health), 16'({6'd35, 6'd26}));
        cyc(0, 1, 3, 0, 0);
        check("p1_87", 16'(p1health), 16'({6'd34, 6'd33}));
        cyc(0, 1, 15, 0, 0);
        check("p1_78_clamp", 16'(p1health), 16'({6'd33, 6'd34}));
        cyc(0, 0, 0, 1, 0);
        check("p2_d0", 16'(p2health), 16'h08E3);

        // Player 2 down to 05, then knocked out with saturation.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 9);
        cyc(0, 0, 0, 1, 4);
        check("p2_05", 16'(p2health), 16'({6'd26, 6'd31}));
        cyc(0, 0, 0, 1, 7);
        check("p2_00", 16'(p2health), 16'({6'd26, 6'd26}));
        check("p1_win", 16'(game_state), 16'd5);
        cyc(0, 1, 9, 1, 9);
        cyc(0, 1, 5, 0, 0);
        check("frozen_p1", 16'(p1health), 16'({6'd33, 6'd34}));
        cyc(1, 0, 0, 0, 0);
        check("win_to_title", 16'(game_state), 16'd0);
        cyc(0, 0, 0, 0, 0);
        check("title_frozen_p1", 16'(p1health), 16'({6'd33, 6'd34}));

        // New match with damage during banners, then simultaneous KO.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3 * P; i++) cyc(0, 1, 5, 1, 5);
        check("banner_no_dmg", 16'(p1health), 16'h08E3);
        for (int i = 0; i < 10; i++) cyc(0, 1, 9, 1, 9);
        cyc(0, 1, 6, 1, 6);
        check("both_03", 16'(p1health), 16'({6'd26, 6'd29}));
        cyc(0, 1, 3, 1, 3);
        check("ko_tie_state", 16'(game_state), 16'd5);
        check("ko_tie_p1", 16'(p1health), 16'({6'd26, 6'd26}));

        // Reset during SET with the counter at 2.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < P + 1; i++) cyc(0, 0, 0, 0, 0);
        check("in_set", 16'(game_state), 16'd2);
        async_reset();

        // Random play.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 15),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 15));
            if (i == 700) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
